led_blink_arbiter: RTL and testbench

//  Shares the single board LED between N_REQ requesters, each requesting a burst of blinks.

---
 rtl/led_blink_arbiter.sv | 167 ++++++++++++++++
 tb/tb_led_blink_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - round-robin sharing of the board LED between N_REQ blink-burst requesters.
// Define LED_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest req index wins).
module led_blink_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HALF_PERIOD = 5000,
    parameter int GAP_CYCLES  = 20000,
    parameter int CNT_W       = 26,
    parameter int BURST_W     = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BURST_W-1:0] burst_len,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic                     LED
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;

    logic [PTR_W-1:0]   win;
    logic               win_vld;
    logic               owner_req;

    // ptr_q doubles as the current owner's index while a burst is running
    assign owner_req = req[ptr_q];

    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
`ifdef LED_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win     = PTR_W'(i);
                win_vld = 1'b1;
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_vld && req[idx]) begin
                win     = PTR_W'(idx);
                win_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                grant_d = '0;
                if (win_vld) begin
                    ptr_d   = win;
                    rem_d   = burst_len[win*BURST_W +: BURST_W];
                    grant_d = N_REQ'(1) << win;
                    if (rem_d != '0) begin
                        state_d = ON;
                    end else begin
                        done_d = grant_d;
                    end
                end
            end
            ON: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                end else if (cnt_q == HALF_LAST) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            end
            OFF: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                end else if (cnt_q == HALF_LAST) begin
                    rem_d   = rem_q - 1'b1;
                    cnt_d   = '0;
                    state_d = (rem_d != '0) ? ON : GAP;
                end
            end
            GAP: begin
                if (!owner_req || cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase

        // done is registered, so it is raised on the edge that enters the last GAP cycle
        if (state_d == GAP && cnt_d == GAP_LAST) begin
            done_d = grant_q;
        end

        busy_d = (state_d != IDLE);
        led_d  = (state_d == ON);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign LED   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb/tb_led_blink_arbiter.sv - directed and random checks of led_blink_arbiter against a burst-timeline model.
module tb_led_blink_arbiter;

    localparam int N   = 4;
    localparam int HP  = 4;
    localparam int GAP = 8;
    localparam int BW  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*BW-1:0] burst_len = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic            led;

    int n_asserts = 0;
    int n_fail    = 0;

    // model state: a burst is a timeline indexed by e = cycles since grant became visible
    bit           m_active;
    int           m_owner, m_ptr, m_len, m_e, m_dur;
    logic [N-1:0] exp_grant, exp_done;
    logic         exp_busy, exp_led;

    led_blink_arbiter #(
        .N_REQ(N), .HALF_PERIOD(HP), .GAP_CYCLES(GAP), .CNT_W(26), .BURST_W(BW)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .req(req), .burst_len(burst_len),
        .grant(grant), .done(done), .busy(busy), .LED(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        exp_grant = '0;
        exp_done  = '0;
        exp_busy  = 1'b0;
        exp_led   = 1'b0;
    endtask

    task automatic timeline_exp();
        exp_grant = N'(1) << m_owner;
        exp_led   = (m_e < 2 * HP * m_len) && ((m_e % (2 * HP)) < HP);
        exp_done  = (m_e == m_dur - 1) ? exp_grant : '0;
        exp_busy  = 1'b1;
    endtask

    task automatic model_step();
        int  w;
        bit  found;
        w     = 0;
        found = 0;
        if (reset) begin
            m_active = 0;
            m_ptr    = N - 1;
            clear_exp();
        end else if (m_active && !req[m_owner]) begin
            m_active = 0;
            clear_exp();
        end else if (m_active && m_e == m_dur - 1) begin
            m_active = 0;
            clear_exp();
        end else if (m_active) begin
            m_e++;
            timeline_exp();
        end else if (req != '0) begin
`ifdef LED_ARB_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
`else
            for (int k = 1; k <= N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    w     = (m_ptr + k) % N;
                    found = 1;
                end
            end
`endif
            m_ptr   = w;
            m_owner = w;
            m_len   = int'(burst_len[w*BW +: BW]);
            if (m_len == 0) begin
                exp_grant = N'(1) << w;
                exp_done  = exp_grant;
                exp_busy  = 1'b0;
                exp_led   = 1'b0;
            end else begin
                m_active = 1;
                m_e      = 0;
                m_dur    = 2 * HP * m_len + GAP;
                timeline_exp();
            end
        end else begin
            clear_exp();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("grant", 32'(grant), 32'(exp_grant));
        check("done",  32'(done),  32'(exp_done));
        check("busy",  32'(busy),  32'(exp_busy));
        check("led",   32'(led),   32'(exp_led));
    endtask

    initial begin
        logic [N-1:0] seq[$];
        logic [N-1:0] prev;
        logic [N-1:0] exp_seq [5];

        m_active = 0;
        m_ptr    = N - 1;
        clear_exp();

        // 1: reset held with all requests asserted
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        req   = '0;
        reset = 1'b0;
        tick();

        // 2: two blinks for requester 1, explicit waveform
        req       = 4'b0010;
        burst_len = 16'h0020;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i <= 24) begin
                check("t2_grant", 32'(grant), 32'h2);
                check("t2_led", 32'(led), 32'((i <= 4) || (i >= 9 && i <= 12)));
                check("t2_done", 32'(done), (i == 24) ? 32'h2 : 32'h0);
            end else begin
                check("t2_grant_end", 32'(grant), 32'h0);
                check("t2_busy_end", 32'(busy), 32'h0);
            end
        end
        req = '0;
        tick();

        // 3: all requesting, length 1 each, grant order from a fresh reset
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req       = 4'b1111;
        burst_len = 16'h1111;
        prev      = '0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (grant != prev && grant != '0) seq.push_back(grant);
            prev = grant;
        end
`ifdef LED_ARB_FIXED_PRIO_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        check("t3_count", 32'(seq.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("t3_order", (i < seq.size()) ? 32'(seq[i]) : 32'hx, 32'(exp_seq[i]));
        end
        req = '0;
        tick();

        // 4: zero-length burst
        req       = 4'b0100;
        burst_len = 16'h0000;
        tick();
        check("t4_grant", 32'(grant), 32'h4);
        check("t4_done", 32'(done), 32'h4);
        check("t4_led", 32'(led), 32'h0);
        req = '0;
        tick();
        check("t4_busy", 32'(busy), 32'h0);

        // 5: abort mid-burst, then check pointer kept at the aborted requester
        req       = 4'b0001;
        burst_len = 16'h0003;
        for (int i = 0; i < 6; i++) tick();
        req = '0;
        tick();
        check("t5_led", 32'(led), 32'h0);
        check("t5_grant", 32'(grant), 32'h0);
        tick();
        check("t5_nodone", 32'(done), 32'h0);
        req       = 4'b0011;
        burst_len = 16'h0011;
        tick();
`ifdef LED_ARB_FIXED_PRIO_EN
        check("t5_next", 32'(grant), 32'h1);
`else
        check("t5_next", 32'(grant), 32'h2);
`endif
        req = '0;
        tick();

        // 6: reset in the middle of a burst
        req       = 4'b0010;
        burst_len = 16'h0020;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        check("t6_grant", 32'(grant), 32'h0);
        check("t6_led", 32'(led), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        req   = '0;
        tick();

`ifdef LED_ARB_FIXED_PRIO_EN
        req       = 4'b1010;
        burst_len = 16'h1111;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t6_fixed", 32'(grant[3]), 32'h0);
        end
        req = '0;
        tick();
`endif

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                for (int j = 0; j < N; j++) burst_len[j*BW +: BW] = BW'($urandom_range(0, 2));
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
